inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
Instruction-fetch memory controller sitting directly upstream of the core's IF stage; supplies the 32-bit instruction word the core consumes on its ROM data input.
- Converts one word request from the core into four sequential byte reads on a byte-wide synchronous RAM (1-cycle read latency).
- Assembles the bytes little-endian and returns the word with a one-cycle valid pulse.
- Supports abort (flush) on branch redirect.

Parameters:
ADDR_W, 17, byte-address width of the instruction RAM port
RESET_PC, 32'h0000_0000, value of last_addr tag after reset (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_i  input  1  core requests the word at addr_i
addr_i  input  32  word address from the PC; bits [1:0] treated as 0
flush_i  input  1  abort any fetch in progress; no valid for aborted request
inst_o  output  32  assembled instruction word
valid_o  output  1  one-cycle pulse: inst_o holds the requested word
busy_o  output  1  high while a fetch is in progress; the core holds the PC
mem_a_o  output  ADDR_W  byte address to the RAM
mem_rd_o  output  1  RAM read enable
mem_din_i  input  8  RAM read data, valid one cycle after mem_a_o/mem_rd_o

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state=IDLE; inst_o=0, valid_o=0, busy_o=0, mem_a_o=0, mem_rd_o=0; internal base address and byte buffer cleared.
- States: IDLE, RD0, RD1, RD2, RD3, CAP3. State transitions occur on the rising edge of clk.
- IDLE:
  - req_i=1 and flush_i=0: latch base={addr_i[31:2],2'b00}, busy_o=1, next=RD0.
  - Otherwise stay in IDLE.
- RDk (k=0..3): mem_rd_o=1, mem_a_o=base[ADDR_W-1:0]+k.
  - In RD1..RD3, capture mem_din_i into byte k-1 of the buffer.
  - Next state is RD(k+1); after RD3 the next state is CAP3.
- CAP3:
  - mem_rd_o=0; capture mem_din_i into byte 3.
  - Next cycle: valid_o=1, inst_o={b3,b2,b1,b0}, busy_o=0, state=IDLE.
- Latency: request accepted at cycle T gives valid_o high at cycle T+6. A new req_i may be accepted in the same cycle valid_o is high, which gives back-to-back fetches every 6 cycles.
- inst_o holds its last value until the next valid; it is never cleared except by rst.
- busy_o=1 in RD0..CAP3.
- mem_a_o is held at its last value when mem_rd_o=0.
- Address arithmetic is modulo 2^ADDR_W: base+3 wraps, so base=2^ADDR_W-4 reads the top 4 bytes with no carry into other bits. Address bits above ADDR_W are ignored.
- flush_i=1 in any state: next state=IDLE, valid_o=0 next cycle, buffer contents don't-care. A req_i in the same cycle is ignored (flush has priority); the core re-issues the request next cycle.
- flush_i in CAP3: valid suppressed.
- rst mid-fetch: identical to reset; no valid is produced.
- req_i while busy_o=1: ignored. addr_i changes while busy_o=1 have no effect.

Optional Feature:
Macro: INST_FETCH_LAST_HIT_EN
- Defined:
  - Keep a one-entry tag (last_addr, last_inst, last_ok).
  - last_ok is set on every completed fetch and cleared by rst and by flush_i.
  - In IDLE, req_i with {addr_i[31:2],2'b00}==last_addr and last_ok=1 returns last_inst with valid_o=1 on the next cycle. No RAM access is made and busy_o stays 0.
- Not defined: every request performs the full 4-byte RAM sequence; no tag storage exists.

Decomposition:
- Shared defines header (the same one the core uses): ZeroWord, InstBus/InstAddrBus widths, RstEnable/ReadEnable constants, and the 3-bit state encodings IFC_IDLE, IFC_RD0..IFC_RD3, IFC_CAP3.
- No sub-module; the FSM, address counter and byte buffer stay in one module. The byte buffer is a 4x8 register indexed by state.

Test Plan:
1. Reset, then RAM bytes 0x00..0x03 = 13,05,10,00; req_i with addr_i=0 -> mem_a_o sequence 0,1,2,3. valid_o is high exactly at T+6 with inst_o=32'h0010_0513; busy_o is high for 5 cycles.
2. addr_i=32'h0000_0006 -> base=4; reads bytes 4..7; inst_o assembled little-endian from bytes 4..7.
3. ADDR_W=17, addr_i=32'h0001_FFFC -> mem_a_o=1FFFC..1FFFF with no wrap error; a second request at 32'h0002_0000 -> mem_a_o=0.
4. flush_i pulsed in RD2 -> next cycle state IDLE, busy_o=0; no valid_o for 10 cycles. A new req_i at addr 8 then completes normally.
5. rst asserted in CAP3 -> next cycle all outputs 0; no valid_o follows.
6. With INST_FETCH_LAST_HIT_EN: fetch addr 0x10, then re-request 0x10 -> valid_o one cycle later, mem_rd_o stays 0. After flush_i, re-request 0x10 -> full 6-cycle fetch.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: bus widths, enable levels and FSM state encodings.
// The same constants are visible to the core through this package.
package inst_fetch_ctrl_pkg;

    localparam int          InstBusW     = 32;
    localparam int          InstAddrBusW = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        RstEnable    = 1'b1;
    localparam logic        ReadEnable   = 1'b1;

    typedef enum logic [2:0] {
        IFC_IDLE = 3'd0,
        IFC_RD0  = 3'd1,
        IFC_RD1  = 3'd2,
        IFC_RD2  = 3'd3,
        IFC_RD3  = 3'd4,
        IFC_CAP3 = 3'd5
    } ifc_state_e;

    function automatic logic [InstAddrBusW-1:0] word_align(input logic [InstAddrBusW-1:0] a);
        return {a[InstAddrBusW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Core-side request/response and byte-RAM signals of the instruction-fetch controller.
// slave = the controller, master = whoever drives requests and RAM read data.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 17
) ();
    import inst_fetch_ctrl_pkg::*;

    logic                    req_i;
    logic [InstAddrBusW-1:0] addr_i;
    logic                    flush_i;
    logic [InstBusW-1:0]     inst_o;
    logic                    valid_o;
    logic                    busy_o;
    logic [ADDR_W-1:0]       mem_a_o;
    logic                    mem_rd_o;
    logic [7:0]              mem_din_i;

    modport slave (
        input  req_i, addr_i, flush_i, mem_din_i,
        output inst_o, valid_o, busy_o, mem_a_o, mem_rd_o
    );

    modport master (
        output req_i, addr_i, flush_i, mem_din_i,
        input  inst_o, valid_o, busy_o, mem_a_o, mem_rd_o
    );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: one word request -> four byte reads, little-endian assembly.
// Optional one-entry last-fetch hit path enabled by INST_FETCH_LAST_HIT_EN.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = 17,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_ctrl_if.slave   bus
);

`ifdef INST_FETCH_LAST_HIT_EN
    localparam int BASE_W = InstAddrBusW;
`else
    localparam int BASE_W = ADDR_W;
`endif

    ifc_state_e              state_q, state_d;
    logic [BASE_W-1:0]       base_q, base_d;
    logic [3:0][7:0]         buf_q, buf_d;
    logic [InstBusW-1:0]     inst_q, inst_d;
    logic                    valid_q, valid_d;
    logic [ADDR_W-1:0]       mem_a_q, mem_a_d;
    logic                    mem_rd_q, mem_rd_d;
    logic [InstAddrBusW-1:0] aligned;
    logic [1:0]              bidx;

    assign aligned = word_align(bus.addr_i);
    assign bidx    = 2'(state_q - IFC_RD1);

`ifdef INST_FETCH_LAST_HIT_EN
    logic [InstAddrBusW-1:0] last_addr_q, last_addr_d;
    logic [InstBusW-1:0]     last_inst_q, last_inst_d;
    logic                    last_ok_q, last_ok_d;
    logic                    hit;

    assign hit = last_ok_q && (aligned == last_addr_q);
`else
    logic unused_ok;
    assign unused_ok = ^{aligned[InstAddrBusW-1:ADDR_W], RESET_PC};
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        buf_d    = buf_q;
        inst_d   = inst_q;
        valid_d  = 1'b0;
        mem_rd_d = 1'b0;
        mem_a_d  = mem_a_q;
`ifdef INST_FETCH_LAST_HIT_EN
        last_addr_d = last_addr_q;
        last_inst_d = last_inst_q;
        last_ok_d   = last_ok_q;
`endif
        case (state_q)
            IFC_IDLE: begin
                if (bus.req_i) begin
`ifdef INST_FETCH_LAST_HIT_EN
                    if (hit) begin
                        valid_d = 1'b1;
                        inst_d  = last_inst_q;
                    end else begin
                        base_d  = aligned[BASE_W-1:0];
                        state_d = IFC_RD0;
                    end
`else
                    base_d  = aligned[BASE_W-1:0];
                    state_d = IFC_RD0;
`endif
                end
            end
            IFC_RD0: state_d = IFC_RD1;
            // RAM data lags the address by one cycle, so RDk captures byte k-1
            IFC_RD1, IFC_RD2, IFC_RD3: begin
                buf_d[bidx] = bus.mem_din_i;
                state_d     = ifc_state_e'(state_q + 3'd1);
            end
            IFC_CAP3: begin
                buf_d[3] = bus.mem_din_i;
                inst_d   = buf_d;
                valid_d  = 1'b1;
                state_d  = IFC_IDLE;
`ifdef INST_FETCH_LAST_HIT_EN
                last_addr_d = base_q;
                last_inst_d = buf_d;
                last_ok_d   = 1'b1;
`endif
            end
            default: state_d = IFC_IDLE;
        endcase

        // flush wins over everything, including a same-cycle request or a completing fetch
        if (bus.flush_i) begin
            state_d = IFC_IDLE;
            base_d  = base_q;
            inst_d  = inst_q;
            valid_d = 1'b0;
`ifdef INST_FETCH_LAST_HIT_EN
            last_addr_d = last_addr_q;
            last_inst_d = last_inst_q;
            last_ok_d   = 1'b0;
`endif
        end

        // address wraps within ADDR_W bits; held when no read is issued
        if (state_d inside {IFC_RD0, IFC_RD1, IFC_RD2, IFC_RD3}) begin
            mem_rd_d = ReadEnable;
            mem_a_d  = base_d[ADDR_W-1:0] + ADDR_W'(state_d - IFC_RD0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= IFC_IDLE;
            base_q   <= '0;
            buf_q    <= '0;
            inst_q   <= ZeroWord;
            valid_q  <= 1'b0;
            mem_a_q  <= '0;
            mem_rd_q <= 1'b0;
`ifdef INST_FETCH_LAST_HIT_EN
            last_addr_q <= RESET_PC;
            last_inst_q <= ZeroWord;
            last_ok_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            buf_q    <= buf_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            mem_a_q  <= mem_a_d;
            mem_rd_q <= mem_rd_d;
`ifdef INST_FETCH_LAST_HIT_EN
            last_addr_q <= last_addr_d;
            last_inst_q <= last_inst_d;
            last_ok_q   <= last_ok_d;
`endif
        end
    end

    assign bus.inst_o   = inst_q;
    assign bus.valid_o  = valid_q;
    assign bus.busy_o   = (state_q != IFC_IDLE);
    assign bus.mem_a_o  = mem_a_q;
    assign bus.mem_rd_o = mem_rd_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: byte RAM model plus a transaction-level reference
// (expected word from RAM contents, fixed 6-cycle latency, one-entry hit tag).
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    localparam int AW = 17;
`ifdef INST_FETCH_LAST_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

    inst_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk) if (bus.mem_rd_o) bus.mem_din_i <= ram[bus.mem_a_o];

    int n_chk  = 0;
    int n_pass = 0;

    bit          m_ok   = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_inst = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram[{a[AW-1:2], 2'd3}], ram[{a[AW-1:2], 2'd2}],
                ram[{a[AW-1:2], 2'd1}], ram[{a[AW-1:2], 2'd0}]};
    endfunction

    // Called at a negedge; returns at the negedge where the result is visible.
    // flush_at: -1 none, else byte-step index (0..4) after which flush is raised.
    task automatic fetch(input logic [31:0] a, input int flush_at, input bit rst_cap);
        logic [31:0] base;
        logic [31:0] exp;
        bit          hit;
        base = {a[31:2], 2'b00};
        exp  = ram_word(a);
        hit  = HIT_EN && m_ok && (m_addr == base);
        bus.req_i   = 1'b1;
        bus.addr_i  = a;
        bus.flush_i = 1'b0;
        @(negedge clk);
        bus.req_i  = 1'($urandom_range(0, 1));
        bus.addr_i = $urandom();
        if (hit) begin
            chk("hit_valid", bus.valid_o, 1);
            chk("hit_inst", bus.inst_o, m_inst);
            chk("hit_busy", bus.busy_o, 0);
            chk("hit_rd", bus.mem_rd_o, 0);
            bus.req_i = 1'b0;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                chk("rd", bus.mem_rd_o, 1);
                chk("addr", bus.mem_a_o, {base[AW-1:2], 2'(i)});
            end else if (i == 4) begin
                chk("rd_cap", bus.mem_rd_o, 0);
            end
            chk("busy", bus.busy_o, (i < 5) ? 1 : 0);
            chk("valid", bus.valid_o, (i == 5) ? 1 : 0);
            if (i == 5) chk("inst", bus.inst_o, exp);
            if (i == flush_at) begin
                bus.flush_i = 1'b1;
                bus.req_i   = 1'($urandom_range(0, 1));
                @(negedge clk);
                bus.flush_i = 1'b0;
                bus.req_i   = 1'b0;
                m_ok = 1'b0;
                chk("fl_busy", bus.busy_o, 0);
                chk("fl_rd", bus.mem_rd_o, 0);
                chk("fl_addr_hold", bus.mem_a_o, {base[AW-1:2], 2'((i > 3) ? 3 : i)});
                for (int j = 0; j < 10; j++) begin
                    chk("fl_novalid", bus.valid_o, 0);
                    @(negedge clk);
                end
                return;
            end
            if (rst_cap && i == 4) begin
                rst       = 1'b1;
                bus.req_i = 1'b0;
                @(negedge clk);
                m_ok = 1'b0;
                chk("rst_inst", bus.inst_o, 0);
                chk("rst_valid", bus.valid_o, 0);
                chk("rst_busy", bus.busy_o, 0);
                chk("rst_addr", bus.mem_a_o, 0);
                chk("rst_rd", bus.mem_rd_o, 0);
                rst = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    @(negedge clk);
                    chk("rst_novalid", bus.valid_o, 0);
                end
                return;
            end
            if (i < 5) begin
                @(negedge clk);
                bus.req_i  = 1'($urandom_range(0, 1));
                bus.addr_i = $urandom();
            end
        end
        bus.req_i = 1'b0;
        m_ok   = 1'b1;
        m_addr = base;
        m_inst = exp;
    endtask

    task automatic flush_idle(input logic [31:0] a);
        bus.flush_i = 1'b1;
        bus.req_i   = 1'b1;
        bus.addr_i  = a;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.req_i   = 1'b0;
        m_ok = 1'b0;
        chk("fi_busy", bus.busy_o, 0);
        chk("fi_valid", bus.valid_o, 0);
        chk("fi_rd", bus.mem_rd_o, 0);
    endtask

    logic [31:0] pool [4] = '{32'h10, 32'h14, 32'h1FFFC, 32'h123};

    initial begin
        for (int k = 0; k < (1 << AW); k++) ram[k] = 8'($urandom());
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
        bus.req_i   = 1'b0;
        bus.addr_i  = '0;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_inst", bus.inst_o, 0);
        chk("reset_valid", bus.valid_o, 0);
        chk("reset_busy", bus.busy_o, 0);
        chk("reset_addr", bus.mem_a_o, 0);
        chk("reset_rd", bus.mem_rd_o, 0);
        rst = 1'b0;
        @(negedge clk);

        fetch(32'h0, -1, 0);
        chk("t1_word", bus.inst_o, 32'h0010_0513);
        fetch(32'h6, -1, 0);
        fetch(32'h0001_FFFC, -1, 0);
        fetch(32'h0002_0000, -1, 0);
        fetch(32'h8, 2, 0);
        fetch(32'h8, -1, 0);
        fetch(32'h40, 4, 0);
        fetch(32'h44, -1, 1);
        flush_idle(32'h44);
        fetch(32'h10, -1, 0);
        fetch(32'h10, -1, 0);
        flush_idle(32'h10);
        fetch(32'h10, -1, 0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          fa;
            case ($urandom_range(0, 3))
                0, 3:    a = pool[$urandom_range(0, 3)];
                1:       a = $urandom();
                default: a = {15'($urandom()), 17'h1FFFC};
            endcase
            fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            fetch(a, fa, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
